// File: rtl/send_data.sv
// On-off keyed carrier transmitter: each byte is sent as a framed symbol sequence
// (start, 8 data bits LSB first, stop) that gates a square-wave carrier onto a 12-bit DAC.
module send_data #(
  parameter int unsigned BIT_CYCLES  = 20'h9C40,
  parameter int unsigned HALF_PERIOD = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [11:0] mean_def,
  input  logic [11:0] amp,
  output logic [11:0] DAC,
  output logic        busy,
  output logic        tx_done
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int PW = $clog2(2 * HALF_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF_PERIOD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    data_reg, data_next;
  logic [11:0]   mean_reg, mean_next;
  logic [11:0]   amp_reg, amp_next;
  logic [11:0]   dac_reg, dac_next;
  logic          done_reg, done_next;
  logic          ready_en_reg;
  logic [11:0]   hi_val, lo_val;
  logic          sym_on;

  function automatic logic [11:0] sat_hi(input logic [11:0] m, input logic [11:0] a);
    logic [12:0] s;
    s = {1'b0, m} + {1'b0, a};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  function automatic logic [11:0] sat_lo(input logic [11:0] m, input logic [11:0] a);
    logic [12:0] d;
    d = {1'b0, m} - {1'b0, a};
    return d[12] ? 12'h000 : d[11:0];
  endfunction

  // ready_en_reg keeps tx_ready low while reset is held, even though state is IDLE
  assign tx_ready = (state_reg == IDLE) && ready_en_reg;
  assign busy     = (state_reg != IDLE);
  assign tx_done  = done_reg;
  assign DAC      = dac_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    data_next  = data_reg;
    mean_next  = mean_reg;
    amp_next   = amp_reg;
    done_next  = 1'b0;
    sym_on     = 1'b0;
    hi_val     = 12'h000;
    lo_val     = 12'h000;
    dac_next   = mean_def;

    if (state_reg == IDLE) begin
      if (tx_valid && tx_ready) begin
        state_next = START;
        cnt_next   = '0;
        phase_next = '0;
        bit_next   = 3'd0;
        data_next  = tx_data;
        mean_next  = mean_def;
        amp_next   = amp;
      end
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      phase_next = '0;
      case (state_reg)
        START: begin
          state_next = DATA;
          bit_next   = 3'd0;
        end
        DATA: begin
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end
        default: begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      endcase
    end else begin
      cnt_next   = cnt_reg + 1'b1;
      phase_next = (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
    end

    // The DAC value is derived from next-state values so it changes on the same edge
    hi_val = sat_hi(mean_next, amp_next);
    lo_val = sat_lo(mean_next, amp_next);
    case (state_next)
      START:   sym_on = 1'b1;
      DATA:    sym_on = data_next[bit_next];
      default: sym_on = 1'b0;
    endcase
    if (state_next == IDLE) dac_next = mean_def;
    else if (sym_on)        dac_next = (phase_next < PH_HALF) ? hi_val : lo_val;
    else                    dac_next = mean_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      phase_reg    <= '0;
      bit_reg      <= 3'd0;
      data_reg     <= 8'h00;
      mean_reg     <= 12'h000;
      amp_reg      <= 12'h000;
      dac_reg      <= 12'h000;
      done_reg     <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      bit_reg      <= bit_next;
      data_reg     <= data_next;
      mean_reg     <= mean_next;
      amp_reg      <= amp_next;
      dac_reg      <= dac_next;
      done_reg     <= done_next;
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_send_data.sv
// Bench for send_data with short symbols: per-frame DAC waveforms are predicted into a
// scoreboard queue at accept time and popped against the DUT every cycle.
module tb_send_data;

  localparam int BC = 100;
  localparam int HP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [11:0] mean_def = 12'h800;
  logic [11:0] amp = 12'h000;
  logic [11:0] dac;
  logic        busy;
  logic        tx_done;

  int vec_count = 0;
  int miss_count = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [11:0] mean;
    logic [11:0] amp;
    logic [11:0] hi;
    logic [11:0] lo;
    bit          hold;
    bit          mutate;
  } vec_t;

  vec_t vecs[8];

  send_data #(.BIT_CYCLES(BC), .HALF_PERIOD(HP)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mean_def(mean_def),
    .amp(amp),
    .DAC(dac),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miss_count++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected frame: start on, data LSB first, stop off; on = hi x HP then lo x HP
  task automatic push_model(input vec_t v);
    bit on;
    for (int s = 0; s < 10; s++) begin
      if (s == 0)      on = 1'b1;
      else if (s == 9) on = 1'b0;
      else             on = v.data[s-1];
      for (int c = 0; c < BC; c++)
        exp_q.push_back(on ? (((c % (2 * HP)) < HP) ? v.hi : v.lo) : v.mean);
    end
  endtask

  // Entered and left at a negedge; leaves in the tx_done cycle
  task automatic run_frame(input vec_t v, input int idx);
    logic [11:0] e;
    int bad, first_cyc, ctl_bad;
    logic [11:0] first_act, first_exp;
    check($sformatf("v%0d_ready_before_accept", idx), tx_ready, 1);
    tx_data  = v.data;
    mean_def = v.mean;
    amp      = v.amp;
    tx_valid = 1'b1;
    push_model(v);
    @(posedge clk);
    ctl_bad = 0;
    bad = 0;
    first_cyc = 0;
    first_act = 0;
    first_exp = 0;
    for (int cyc = 0; cyc < 10 * BC; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !v.hold) tx_valid = 1'b0;
      if (exp_q.size() == 0) e = 12'hXXX;
      else e = exp_q.pop_front();
      if (dac !== e) begin
        if (bad == 0) begin
          first_cyc = cyc;
          first_act = dac;
          first_exp = e;
        end
        bad++;
      end
      if (busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) ctl_bad++;
      if (v.mutate && cyc == 300) begin
        tx_data  = ~tx_data;
        mean_def = 12'h123;
        amp      = 12'hFFF;
      end
      if (cyc % BC == BC - 1) begin
        vec_count++;
        if (bad != 0) begin
          miss_count++;
          $display("FAIL v%0d_sym%0d_dac: %0d cycles wrong, first at cycle %0d got %h required %h",
                   idx, cyc / BC, bad, first_cyc, first_act, first_exp);
        end
        bad = 0;
      end
    end
    check($sformatf("v%0d_ctl_bad_cycles", idx), ctl_bad, 0);
    @(negedge clk);
    check($sformatf("v%0d_tx_done", idx), tx_done, 1);
    check($sformatf("v%0d_busy_after", idx), busy, 0);
    check($sformatf("v%0d_ready_after", idx), tx_ready, 1);
    check($sformatf("v%0d_idle_dac", idx), dac, mean_def);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 12'h800, 12'h200, 12'hA00, 12'h600, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 12'hF00, 12'h200, 12'hFFF, 12'hD00, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 12'h100, 12'h200, 12'h300, 12'h000, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 12'h800, 12'h000, 12'h800, 12'h800, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 12'h800, 12'h200, 12'hA00, 12'h600, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 12'h800, 12'h200, 12'hA00, 12'h600, 1'b0, 1'b0};
    vecs[6] = '{8'h96, 12'h800, 12'h200, 12'hA00, 12'h600, 1'b0, 1'b1};
    vecs[7] = '{8'h81, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 1'b0};

    @(negedge clk);
    check("reset_dac", dac, 12'h000);
    check("reset_ready", tx_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", tx_ready, 1);
    check("post_reset_dac", dac, 12'h800);
    mean_def = 12'h456;
    #1;
    check("idle_latency_old", dac, 12'h800);
    @(negedge clk);
    check("idle_follow_new", dac, 12'h456);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], i);
      if (!vecs[i].hold) begin
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", i), tx_done, 0);
      end
    end

    // Abort a frame with reset part-way through
    tx_data  = 8'h3C;
    mean_def = 12'h800;
    amp      = 12'h200;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (349) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_dac", dac, 12'h000);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 0);
    check("abort_done", tx_done, 0);
    @(negedge clk);
    check("abort_hold_dac", dac, 12'h000);
    check("abort_hold_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", tx_ready, 1);
    check("abort_release_dac", dac, 12'h800);
    check("abort_release_done", tx_done, 0);
    run_frame(vecs[0], 8);
    @(negedge clk);
    check("v8_done_one_cycle", tx_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
